// File: rtl/frame_update_ctrl.sv
// frame_update_ctrl
// Issues one game-state update request per video frame at vblank start.
// Conditions the raw buttons (2-FF sync, per-bit debounce, rising-edge capture)
// and hands the captured presses to the scene through a req/done handshake.

module frame_update_ctrl #(
    parameter int V_VISIBLE  = 480,
    parameter int NBTN       = 9,
    parameter int DEB_CYCLES = 250000,
    parameter int FCW        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [9:0]      h_cnt,
    input  logic [9:0]      v_cnt,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            upd_done,
    output logic            upd_req,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_level,
    output logic            in_vblank,
    output logic [FCW-1:0]  frame_cnt,
    output logic            overrun
);

    localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [9:0]    V_START = 10'(V_VISIBLE);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [CW-1:0]   r_deb_cnt [NBTN];
    logic [NBTN-1:0] r_level;
    logic [NBTN-1:0] r_level_q;
    logic [NBTN-1:0] r_acc;
    logic [NBTN-1:0] r_press;
    logic            r_in_vblank;
    logic [FCW-1:0]  r_frame_cnt;
    logic            r_overrun;

    logic            w_vblank_start;
    logic [NBTN-1:0] w_rise;
    logic            w_snap;
    logic            w_done;
    logic            w_ovr;

    assign w_vblank_start = (h_cnt == '0) && (v_cnt == V_START);
    assign w_rise         = r_level & ~r_level_q;

    // Two-stage synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: a level change is accepted after DEB_CYCLES consecutive
    // mismatching samples; any matching sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NBTN; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_MAX) begin
                    r_level[i]   <= ~r_level[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= '0;
        end else begin
            r_level_q <= r_level;
        end
    end

    // Registered vblank flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_vblank <= 1'b0;
        end else begin
            r_in_vblank <= (v_cnt >= V_START);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and datapath strobes; done has priority over a coinciding vblank.
    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        w_done      = 1'b0;
        w_ovr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vblank_start) begin
                    w_state_nxt = ST_BUSY;
                    w_snap      = 1'b1;
                end
            end
            ST_BUSY: begin
                if (upd_done) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end else if (w_vblank_start) begin
                    w_ovr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Press accumulator and snapshot; a rise in the snapshot cycle lands in the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_press <= '0;
        end else if (w_snap) begin
            r_acc   <= '0;
            r_press <= r_acc | w_rise;
        end else begin
            r_acc   <= r_acc | w_rise;
        end
    end

    // Completed-update counter (wraps silently) and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_ovr) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign upd_req   = (r_state == ST_BUSY);
    assign btn_press = r_press;
    assign btn_level = r_level;
    assign in_vblank = r_in_vblank;
    assign frame_cnt = r_frame_cnt;
    assign overrun   = r_overrun;

endmodule
